// File: rtl/buf512to64_stream_ctrl.sv
// Transfer sequencer for one 512->64 line buffer: feeds upstream lines in,
// pops words out with a last flag, then clears any partial-line tail.
module buf512to64_stream_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic [511:0]     buf_data_in,
    output logic             buf_wr_enable,
    output logic             buf_rd_enable,
    output logic             buf_clr,
    input  logic [63:0]      buf_data_out,
    input  logic             buf_full,
    input  logic             buf_empty,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int LINE_W = LEN_W - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    words_left_q, words_left_d;
    logic [LINE_W-1:0]   lines_left_q, lines_left_d;
    logic [LINE_W-1:0]   lines_init;
    logic                aborted_q, aborted_d;
    logic                busy_q, done_q, clr_q;
    logic                run;

    // ceil(len/8) without a wide intermediate: whole lines plus one if a tail exists
    assign lines_init = {1'b0, len_words[LEN_W-1:3]} + LINE_W'(|len_words[2:0]);

    assign run           = (state_q == S_RUN);
    assign in_ready      = run && !buf_full && (lines_left_q != '0);
    assign buf_wr_enable = in_valid && in_ready;
    assign buf_data_in   = in_data;

    assign out_valid     = run && !buf_empty && (words_left_q != '0);
    assign out_data      = buf_data_out;
    assign out_last      = out_valid && (words_left_q == LEN_W'(1));
    assign buf_rd_enable = out_valid && out_ready;

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign buf_clr = clr_q;

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        lines_left_d = lines_left_q;
        aborted_d    = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    aborted_d    = 1'b0;
                    words_left_d = len_words;
                    lines_left_d = lines_init;
                    state_d      = (len_words != '0) ? S_RUN : S_FLUSH;
                end
            end
            S_RUN: begin
                if (buf_wr_enable) lines_left_d = lines_left_q - LINE_W'(1);
                if (buf_rd_enable) words_left_d = words_left_q - LEN_W'(1);
                // a pop coinciding with abort still completes above
                if (abort) begin
                    state_d   = S_FLUSH;
                    aborted_d = 1'b1;
                end else if (buf_rd_enable && words_left_q == LEN_W'(1)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            lines_left_q <= '0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            clr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            lines_left_q <= lines_left_d;
            aborted_q    <= aborted_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            clr_q        <= (state_d == S_FLUSH);
        end
    end

endmodule

// File: tb/tb_buf512to64_stream_ctrl.sv
// Bench for buf512to64_stream_ctrl with a two-line FWFT buffer model attached.
module tb_buf512to64_stream_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, in_valid, out_ready;
    logic [15:0]   len_words;
    logic [511:0]  in_data;
    logic          in_ready, out_valid, out_last;
    logic [63:0]   out_data;
    logic [511:0]  buf_data_in;
    logic          buf_wr_enable, buf_rd_enable, buf_clr;
    logic [63:0]   buf_data_out;
    logic          buf_full, buf_empty;
    logic          busy, done, aborted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    buf512to64_stream_ctrl #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len_words(len_words), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .buf_data_in(buf_data_in), .buf_wr_enable(buf_wr_enable), .buf_rd_enable(buf_rd_enable),
        .buf_clr(buf_clr), .buf_data_out(buf_data_out), .buf_full(buf_full), .buf_empty(buf_empty),
        .busy(busy), .done(done), .aborted(aborted)
    );

    // Buffer model: 16 words deep, full once another whole line will not fit
    logic [63:0] bq [16];
    logic [63:0] nq [16];
    int          bcnt, ncnt;

    always_comb begin
        nq   = bq;
        ncnt = bcnt;
        if (buf_rd_enable && bcnt > 0) begin
            for (int i = 0; i < 15; i++) nq[i] = bq[i+1];
            ncnt = bcnt - 1;
        end
        if (buf_wr_enable) begin
            for (int j = 0; j < 8; j++)
                if (ncnt + j < 16) nq[ncnt+j] = buf_data_in[j*64 +: 64];
            ncnt = ncnt + 8;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bcnt <= 0;
        else if (buf_clr) bcnt <= 0;
        else begin
            bq   <= nq;
            bcnt <= ncnt;
        end
    end

    assign buf_data_out = bq[0];
    assign buf_empty    = (bcnt == 0);
    assign buf_full     = (bcnt > 8);

    function automatic logic [511:0] mkline(input int n);
        logic [511:0] r;
        for (int j = 0; j < 8; j++) r[j*64 +: 64] = 64'(n*8 + j + 1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        s;
        logic [15:0] len;
        logic        ab, iv, ordy;
        logic        e_ir, e_ov;
        logic [63:0] e_d;
        logic        e_last, e_busy, e_done, e_abt, e_clr;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic s, input logic [15:0] len, input logic ab,
                                input logic iv, input logic ordy, input logic ir, input logic ov,
                                input logic [63:0] d, input logic last, input logic bsy,
                                input logic dn, input logic abt, input logic clr);
        vec_t v;
        v.s = s; v.len = len; v.ab = ab; v.iv = iv; v.ordy = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_d = d; v.e_last = last;
        v.e_busy = bsy; v.e_done = dn; v.e_abt = abt; v.e_clr = clr;
        tbl.push_back(v);
    endfunction

    // transfer results
    logic [63:0] got[$];
    int wr_cnt, clr_cnt, clr_cyc, done_cyc, last_cnt, last_idx;
    int stall_viol, full_viol, post_valid;
    logic abt_at_done, empty_at_done;

    task automatic run_xfer(input int len, input int n_off, input bit toggle, input int abort_at);
        int   cyc = 0;
        int   line = 0;
        bit   prev_stall = 0;
        logic [63:0] prev_d = '0;
        bit   ab_sent = 0;
        int   ab_cyc = -1;
        got.delete();
        wr_cnt = 0; clr_cnt = 0; clr_cyc = -1; done_cyc = -100; last_cnt = 0; last_idx = -1;
        stall_viol = 0; full_viol = 0; post_valid = 0; abt_at_done = 0; empty_at_done = 0;
        @(posedge clk); #1;
        start = 1'b1; len_words = 16'(len); abort = 1'b0; out_ready = 1'b1;
        in_valid = (line < n_off); in_data = mkline(line);
        while (1) begin
            @(negedge clk);
            if (buf_full && in_ready) full_viol++;
            if (prev_stall && (!out_valid || out_data !== prev_d)) stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if (ab_sent && cyc > ab_cyc && out_valid) post_valid++;
            if (buf_wr_enable) begin wr_cnt++; line++; end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_last) begin last_cnt++; last_idx = got.size() - 1; end
            end
            if (buf_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (done) begin
                done_cyc = cyc; abt_at_done = aborted; empty_at_done = buf_empty;
                break;
            end
            if (cyc >= 400) begin
                chk("xfer_timeout", 64'(cyc), 64'(0));
                break;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; abort = 1'b0;
            in_valid = (line < n_off); in_data = mkline(line);
            out_ready = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (abort_at >= 0 && !ab_sent && got.size() == abort_at) begin
                abort = 1'b1; out_ready = 1'b0; ab_sent = 1; ab_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic check_seq(input string nm, input int n_exp);
        int bad = 0;
        chk({nm, "_count"}, 64'(got.size()), 64'(n_exp));
        foreach (got[i]) if (got[i] !== 64'(i + 1)) bad++;
        chk({nm, "_order"}, 64'(bad), 64'(0));
    endtask

    initial begin
        int n;
        int line;
        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        len_words = '0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0); chk("rst_clr", buf_clr, 0);
        chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
        chk("rst_wr", buf_wr_enable, 0); chk("rst_rd", buf_rd_enable, 0);
        @(posedge clk); #1 rst = 1'b1;

        // zero-length start (second start ignored), then an 8-word transfer
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(k == 3, 3, 0, 1, 1, 0, 1, 64'(k), k == 8, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            start = tbl[i].s; len_words = tbl[i].len; abort = tbl[i].ab;
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; in_data = mkline(0);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("v%0d_aborted", i), aborted, tbl[i].e_abt);
            chk($sformatf("v%0d_clr", i), buf_clr, tbl[i].e_clr);
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d_data", i), out_data, tbl[i].e_d);
                chk($sformatf("v%0d_last", i), out_last, tbl[i].e_last);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;

        // three full lines
        run_xfer(24, 3, 0, -1);
        check_seq("l24", 24);
        chk("l24_wr", 64'(wr_cnt), 3);     chk("l24_clr", 64'(clr_cnt), 1);
        chk("l24_last_cnt", 64'(last_cnt), 1); chk("l24_last_idx", 64'(last_idx), 23);
        chk("l24_done_gap", 64'(done_cyc - clr_cyc), 1);
        chk("l24_aborted", abt_at_done, 0); chk("l24_empty", empty_at_done, 1);

        // partial final line, extra line offered
        run_xfer(10, 3, 0, -1);
        check_seq("l10", 10);
        chk("l10_wr", 64'(wr_cnt), 2);     chk("l10_last_idx", 64'(last_idx), 9);
        chk("l10_clr", 64'(clr_cnt), 1);   chk("l10_empty", empty_at_done, 1);

        // downstream backpressure
        run_xfer(16, 2, 1, -1);
        check_seq("l16bp", 16);
        chk("l16bp_stall", 64'(stall_viol), 0); chk("l16bp_full", 64'(full_viol), 0);
        chk("l16bp_last_idx", 64'(last_idx), 15);

        // abort after word 5, then a normal transfer
        run_xfer(24, 3, 0, 5);
        check_seq("abort", 5);
        chk("abort_post_valid", 64'(post_valid), 0); chk("abort_clr", 64'(clr_cnt), 1);
        chk("abort_flag", abt_at_done, 1);  chk("abort_last", 64'(last_cnt), 0);
        chk("abort_empty", empty_at_done, 1);
        run_xfer(8, 1, 0, -1);
        check_seq("after_abort", 8);
        chk("after_abort_flag", abt_at_done, 0);

        // asynchronous reset mid-transfer
        n = 0; line = 0;
        @(posedge clk); #1;
        start = 1'b1; len_words = 16'd24; in_valid = 1'b1; in_data = mkline(0); out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (buf_wr_enable) line++;
            if (out_valid && out_ready) n++;
            if (n == 3) break;
            @(posedge clk); #1;
            start = 1'b0; in_valid = (line < 3); in_data = mkline(line);
        end
        chk("rstmid_reached", 64'(n), 3);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_in_ready", in_ready, 0); chk("rstmid_wr", buf_wr_enable, 0);
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_done", done, 0);
        end
        @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
        run_xfer(8, 1, 0, -1);
        check_seq("post_rst", 8);
        chk("post_rst_last_idx", 64'(last_idx), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
